// File: rtl/sid_filter_pkg.sv
// rtl/sid_filter_pkg.sv - shared FSM states, saturation helper and filter shift constants

package sid_filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_HP,
        ST_BP,
        ST_LP,
        ST_OUT
    } state_t;

    localparam int A1_SHIFT = 5;
    localparam int A2_SHIFT = 3;

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sid_filter_mux_svf_step.sv
// rtl/sid_filter_mux_svf_step.sv - shared shift-add datapath for the HP/BP/LP filter steps

module svf_step
    import sid_filter_pkg::*;
#(
    parameter int SW = 10
) (
    input  logic signed [SW+1:0] base,
    input  logic signed [SW-1:0] x,
    input  logic [4:0]           coef,
    input  logic [2:0]           shift,
    input  logic                 sub,
    output logic signed [SW-1:0] y
);

    logic signed [31:0] base_w;
    logic signed [31:0] x_w;
    logic signed [31:0] coef_w;
    logic signed [31:0] term;
    logic signed [31:0] total;

    // The shift floors because it is applied to the signed product as a whole.
    always_comb begin
        base_w = {{(32 - SW - 2){base[SW+1]}}, base};
        x_w    = {{(32 - SW){x[SW-1]}}, x};
        coef_w = {27'd0, coef};
        term   = (x_w * coef_w) >>> shift;
        total  = sub ? (base_w - term) : (base_w + term);
        y      = SW'(sat(total, SW));
    end

endmodule

// File: rtl/sid_filter_mux.sv
// rtl/sid_filter_mux.sv - N-voice SID filter router with shared state-variable filter and cutoff glide

module sid_filter_mux
    import sid_filter_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 3,
    parameter int GLIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   sample_in,
    input  logic             sample_valid,
    input  logic [10:0]      fc,
    input  logic [3:0]       res,
    input  logic [N-1:0]     filt,
    input  logic [3:0]       mode,
    input  logic [3:0]       vol,
    output logic [W-1:0]     sample_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int SW    = W + 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = W + CNT_W + 1;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N*W-1:0]           smp_q, smp_d;
    logic [4:0]               tgt_q, tgt_d;
    logic [3:0]               res_q, res_d;
    logic [N-1:0]             filt_q, filt_d;
    logic [3:0]               mode_q, mode_d;
    logic [3:0]               vol_q, vol_d;
    logic signed [ACC_W-1:0]  f_sum_q, f_sum_d;
    logic signed [ACC_W-1:0]  d_sum_q, d_sum_d;
    logic signed [SW-1:0]     hp_q, hp_d;
    logic signed [SW-1:0]     bp_q, bp_d;
    logic signed [SW-1:0]     lp_q, lp_d;
    logic [4:0]               a1_q, a1_d;
    logic [W-1:0]             sample_out_q, sample_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     unused_fc;
    logic                     bypass;
    logic [W-1:0]             cur_voice;
    logic signed [ACC_W-1:0]  s_ext;
    logic signed [31:0]       f_w, d_w, hp_w, bp_w, lp_w, mix_full;
    logic signed [SW-1:0]     fin;
    logic [W-1:0]             mix_w;
    logic [W-1:0]             pre_u;
    logic [W+3:0]             scaled;

    logic signed [SW+1:0]     step_base;
    logic signed [SW-1:0]     step_x;
    logic [4:0]               step_coef;
    logic [2:0]               step_shift;
    logic                     step_sub;
    logic signed [SW-1:0]     step_y;

    assign unused_fc  = ^fc[5:0];
    assign bypass     = (filt_q == '0) || (mode_q[2:0] == 3'b000);
    assign busy       = (state_q != ST_IDLE);
    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

    // Offset-binary to two's complement is just an MSB flip.
    always_comb begin
        cur_voice = smp_q[cnt_q*W +: W];
        s_ext     = {{(ACC_W - W){~cur_voice[W-1]}}, ~cur_voice[W-1], cur_voice[W-2:0]};
        f_w       = {{(32 - ACC_W){f_sum_q[ACC_W-1]}}, f_sum_q};
        d_w       = {{(32 - ACC_W){d_sum_q[ACC_W-1]}}, d_sum_q};
        hp_w      = {{(32 - SW){hp_q[SW-1]}}, hp_q};
        bp_w      = {{(32 - SW){bp_q[SW-1]}}, bp_q};
        lp_w      = {{(32 - SW){lp_q[SW-1]}}, lp_q};
        fin       = SW'(sat(f_w, SW));
        if (bypass) begin
            mix_full = f_w + d_w;
        end else begin
            mix_full = d_w + (mode_q[0] ? lp_w : 32'sd0)
                           + (mode_q[1] ? bp_w : 32'sd0)
                           + (mode_q[2] ? hp_w : 32'sd0);
        end
        mix_w  = W'(sat(mix_full, W));
        pre_u  = {~mix_w[W-1], mix_w[W-2:0]};
        scaled = (W+4)'(pre_u) * (W+4)'(vol_q);
    end

    always_comb begin
        step_base  = {{2{bp_q[SW-1]}}, bp_q};
        step_x     = hp_q;
        step_coef  = a1_q;
        step_shift = 3'(A1_SHIFT);
        step_sub   = 1'b0;
        if (state_q == ST_HP) begin
            step_base  = {{2{fin[SW-1]}}, fin} - {{2{lp_q[SW-1]}}, lp_q};
            step_x     = bp_q;
            step_coef  = {1'b0, 4'd15 - res_q};
            step_shift = 3'(A2_SHIFT);
            step_sub   = 1'b1;
        end else if (state_q == ST_LP) begin
            step_base  = {{2{lp_q[SW-1]}}, lp_q};
            step_x     = bp_q;
        end
    end

    svf_step #(.SW(SW)) u_step (
        .base  (step_base),
        .x     (step_x),
        .coef  (step_coef),
        .shift (step_shift),
        .sub   (step_sub),
        .y     (step_y)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        smp_d        = smp_q;
        tgt_d        = tgt_q;
        res_d        = res_q;
        filt_d       = filt_q;
        mode_d       = mode_q;
        vol_d        = vol_q;
        f_sum_d      = f_sum_q;
        d_sum_d      = d_sum_q;
        hp_d         = hp_q;
        bp_d         = bp_q;
        lp_d         = lp_q;
        a1_d         = a1_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = sample_valid && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    smp_d   = sample_in;
                    tgt_d   = fc[10:6];
                    res_d   = res;
                    filt_d  = filt;
                    mode_d  = mode;
                    vol_d   = vol;
                    f_sum_d = '0;
                    d_sum_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (filt_q[cnt_q]) begin
                    f_sum_d = f_sum_q + s_ext;
                end else if (!((cnt_q == CNT_W'(N - 1)) && mode_q[3])) begin
                    d_sum_d = d_sum_q + s_ext;
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_HP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HP: begin
                if (!bypass) hp_d = step_y;
                state_d = ST_BP;
            end
            ST_BP: begin
                if (!bypass) bp_d = step_y;
                state_d = ST_LP;
            end
            ST_LP: begin
                if (!bypass) lp_d = step_y;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                sample_out_d = W'(scaled >> 4);
                out_valid_d  = 1'b1;
                if (GLIDE != 0) begin
                    if (a1_q < tgt_q) begin
                        a1_d = a1_q + 5'd1;
                    end else if (a1_q > tgt_q) begin
                        a1_d = a1_q - 5'd1;
                    end
                end else begin
                    a1_d = tgt_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            smp_q        <= '0;
            tgt_q        <= '0;
            res_q        <= '0;
            filt_q       <= '0;
            mode_q       <= '0;
            vol_q        <= '0;
            f_sum_q      <= '0;
            d_sum_q      <= '0;
            hp_q         <= '0;
            bp_q         <= '0;
            lp_q         <= '0;
            a1_q         <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            smp_q        <= smp_d;
            tgt_q        <= tgt_d;
            res_q        <= res_d;
            filt_q       <= filt_d;
            mode_q       <= mode_d;
            vol_q        <= vol_d;
            f_sum_q      <= f_sum_d;
            d_sum_q      <= d_sum_d;
            hp_q         <= hp_d;
            bp_q         <= bp_d;
            lp_q         <= lp_d;
            a1_q         <= a1_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
